alu_ctrl_seq: RTL and testbench
===============================

# alu_ctrl_seq

Sequencing controller for the execute-stage datapath (ALU, shifter, Hi/Lo registers and the output MUX). Accepts one function code at a time over a valid/ready handshake and drives the registered MUX select. Runs single-cycle ops in one EXEC cycle and MULTU as a multi-cycle shift-add sequence ending in a Hi/Lo write. Sits between instruction decode and the datapath and is the only writer of the MUX `Signal` select.

## Interface
- MULT_CYCLES, 32, number of MultStep cycles per MULTU (one per multiplier bit); 2..63.
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- FunctIn  input  6  function code: AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, SRL 000010, MFHI 010000, MFLO 010010, MULTU 011001.
- Valid  input  1  FunctIn valid.
- Ready  output  1  controller can accept; high only in IDLE.
- Signal  output  6  registered MUX/ALU select to datapath.
- MultLoad  output  1  load multiplicand/multiplier, clear product.
- MultStep  output  1  advance shift-add multiplier one bit.
- HiLoWrite  output  1  commit product to Hi/Lo.
- Done  output  1  one-cycle completion pulse.
- IllegalOp  output  1  one-cycle pulse, with Done, for unsupported code.

## Operation
- States: IDLE, EXEC, MLOAD, MSTEP, MWRITE.
- IDLE: Ready=1. Handshake fires on Valid&&Ready at a rising edge.
- Legal single-cycle code: Signal<=FunctIn; go to EXEC. EXEC: Done=1 for one cycle, then IDLE.
- MULTU: Signal unchanged; go to MLOAD (MultLoad=1), then MSTEP for exactly MULT_CYCLES cycles (MultStep=1), then MWRITE (HiLoWrite=1, Done=1), then IDLE.
- Illegal code: go to EXEC with IllegalOp=1, Done=1; Signal keeps its previous value.
- Step counter: 6 bits, cleared in MLOAD, incremented in MSTEP; leave MSTEP when count==MULT_CYCLES-1. No wrap in normal use.
- Valid while Ready=0 is ignored. The upstream holds FunctIn/Valid until accepted. No queueing.
- MFHI/MFLO cannot overlap a MULTU because Ready=0 during the sequence, so Hi/Lo reads always see the committed product.
- Reset mid-sequence: everything returns to reset values immediately. No HiLoWrite is issued and no Done is issued for the aborted op.

## Timing
- Reset values: state=IDLE, Ready=1, Signal=6'b100000 (ADD), MultLoad=MultStep=HiLoWrite=Done=IllegalOp=0, counter=0.
- Accept at edge T:
  - Single-cycle or illegal op: Signal valid and Done=1 during T+1; Ready=0 in T+1, Ready=1 in T+2. Throughput is one op per 2 cycles.
  - MULTU: MultLoad in T+1, MultStep in T+2..T+1+MULT_CYCLES, HiLoWrite and Done in T+2+MULT_CYCLES, Ready=1 in T+3+MULT_CYCLES.
- All outputs are Moore (decoded from state). Ready has no combinational path from Valid.

## Configuration
- ALU_CTRL_DIVU_EN defined: code 011011 (DIVU) is accepted. It uses the same MLOAD/MSTEP/MWRITE sequence and timing, with extra output DivMode (1 bit), held high for the whole sequence, so the datapath's shared shift unit runs restoring division.
- Not defined: DIVU is an illegal code (IllegalOp pulse) and the DivMode port does not exist.

## Structure
- Shared package alu_ctrl_pkg: function-code constants (including DIVU), state encoding, reset Signal value.
- One sub-module, alu_ctrl_cnt: the step counter, with clear, enable and terminal-count output (parameter MULT_CYCLES).

## Test plan
- Reset released, idle: Ready=1, Signal=100000, all pulses 0.
- Valid with FunctIn=100010 (SUB) at T: Signal=100010 and Done=1 at T+1; Ready=1 at T+2.
- Valid with FunctIn=011001 (MULTU): MultLoad 1 cycle, MultStep exactly 32 cycles, HiLoWrite+Done at T+34. A following MFHI is held off until Ready=1 at T+35; then Signal=010000.
- FunctIn=111111: IllegalOp=1 and Done=1 at T+1; Signal unchanged from the previous op.
- Reset asserted during MSTEP (count 10): outputs go to reset values at once; no HiLoWrite and no Done follow after release.
- With ALU_CTRL_DIVU_EN, FunctIn=011011: DivMode=1 for T+1..T+34 and sequence timing identical to MULTU. Without the macro: IllegalOp pulse.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg -- shared definitions for the execute-stage sequencing controller.
//   * function-code constants (DIVU included; whether it is accepted is decided
//     in alu_ctrl_seq under ALU_CTRL_DIVU_EN)
//   * controller state encoding
//   * reset value of the datapath MUX select
//   * is_single(): true for codes that complete in one EXEC cycle
package alu_ctrl_pkg;

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [5:0] SIGNAL_RST = F_ADD;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXEC   = 3'd1,
    S_MLOAD  = 3'd2,
    S_MSTEP  = 3'd3,
    S_MWRITE = 3'd4
  } state_t;

  function automatic logic is_single(input logic [5:0] f);
    case (f)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SRL, F_MFHI, F_MFLO: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// alu_ctrl_seq_if -- bus between instruction decode (master) and the
// sequencing controller (slave).
//   FunctIn[5:0]  decode -> ctrl   function code
//   Valid         decode -> ctrl   FunctIn valid
//   Ready         ctrl -> decode   controller can accept
//   Signal[5:0]   ctrl -> datapath registered MUX/ALU select
//   MultLoad      ctrl -> datapath load multiplicand/multiplier, clear product
//   MultStep      ctrl -> datapath advance shift-add one bit
//   HiLoWrite     ctrl -> datapath commit product to Hi/Lo
//   Done          ctrl -> decode   one-cycle completion pulse
//   IllegalOp     ctrl -> decode   one-cycle pulse with Done for bad code
//   DivMode       ctrl -> datapath (only with ALU_CTRL_DIVU_EN) restoring divide
interface alu_ctrl_seq_if;
  logic [5:0] FunctIn;
  logic       Valid;
  logic       Ready;
  logic [5:0] Signal;
  logic       MultLoad;
  logic       MultStep;
  logic       HiLoWrite;
  logic       Done;
  logic       IllegalOp;
`ifdef ALU_CTRL_DIVU_EN
  logic       DivMode;

  modport master (
    output FunctIn, Valid,
    input  Ready, Signal, MultLoad, MultStep, HiLoWrite, Done, IllegalOp, DivMode
  );
  modport slave (
    input  FunctIn, Valid,
    output Ready, Signal, MultLoad, MultStep, HiLoWrite, Done, IllegalOp, DivMode
  );
`else
  modport master (
    output FunctIn, Valid,
    input  Ready, Signal, MultLoad, MultStep, HiLoWrite, Done, IllegalOp
  );
  modport slave (
    input  FunctIn, Valid,
    output Ready, Signal, MultLoad, MultStep, HiLoWrite, Done, IllegalOp
  );
`endif
endinterface

// File: rtl/alu_ctrl_cnt.sv
// alu_ctrl_cnt -- 6-bit step counter for the multi-cycle shift-add sequence.
//   clk    clock
//   rst_n  asynchronous active-low reset (count -> 0)
//   clr    synchronous clear (has priority over en)
//   en     increment by one
//   tc     terminal count: count == MULT_CYCLES-1
module alu_ctrl_cnt #(
  parameter int MULT_CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [5:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (en)     cnt <= cnt + 6'd1;
  end

  assign tc = (cnt == 6'(MULT_CYCLES - 1));

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq -- execute-stage sequencing controller.
// Accepts one function code per valid/ready handshake (only while IDLE) and
// drives the registered datapath select. Single-cycle codes spend one EXEC
// cycle; MULTU runs MLOAD, MULT_CYCLES x MSTEP, MWRITE. Unsupported codes
// take one EXEC cycle with IllegalOp and leave Signal untouched.
// Optional feature macro: ALU_CTRL_DIVU_EN -- accept DIVU through the same
// sequence as MULTU and drive DivMode high for the whole sequence.
// Ports:
//   clk    clock, all state on rising edge
//   reset  asynchronous active-low reset
//   bus    alu_ctrl_seq_if.slave (FunctIn/Valid in, everything else out)
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 32
) (
  input  logic            clk,
  input  logic            reset,
  alu_ctrl_seq_if.slave   bus
);

  state_t     state, state_nxt;
  logic [5:0] sig_q;
  logic       ill_q;
  logic       accept;
  logic       code_single;
  logic       code_div;
  logic       code_seq;
  logic       tc;

  logic       ready_o, mload_o, mstep_o, hlwr_o, done_o, ill_o;

  assign accept      = bus.Valid && (state == S_IDLE);
  assign code_single = is_single(bus.FunctIn);
`ifdef ALU_CTRL_DIVU_EN
  assign code_div    = (bus.FunctIn == F_DIVU);
`else
  assign code_div    = 1'b0;
`endif
  assign code_seq    = (bus.FunctIn == F_MULTU) || code_div;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = code_seq ? S_MLOAD : S_EXEC;
      S_EXEC:   state_nxt = S_IDLE;
      S_MLOAD:  state_nxt = S_MSTEP;
      S_MSTEP:  if (tc) state_nxt = S_MWRITE;
      S_MWRITE: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output decode (Moore)
  always_comb begin
    ready_o = 1'b0;
    mload_o = 1'b0;
    mstep_o = 1'b0;
    hlwr_o  = 1'b0;
    done_o  = 1'b0;
    ill_o   = 1'b0;
    case (state)
      S_IDLE:   ready_o = 1'b1;
      S_EXEC: begin
        done_o = 1'b1;
        ill_o  = ill_q;
      end
      S_MLOAD:  mload_o = 1'b1;
      S_MSTEP:  mstep_o = 1'b1;
      S_MWRITE: begin
        hlwr_o = 1'b1;
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Select register and per-op flags, captured on the accepting edge. The
  // select only changes for single-cycle codes so illegal ops and MULTU leave
  // the datapath pointing at the previous result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig_q <= SIGNAL_RST;
      ill_q <= 1'b0;
    end else if (accept) begin
      if (code_single) sig_q <= bus.FunctIn;
      ill_q <= !code_single && !code_seq;
    end
  end

`ifdef ALU_CTRL_DIVU_EN
  logic div_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      div_q <= 1'b0;
    else if (accept) div_q <= code_div;
  end

  assign bus.DivMode = div_q &&
                       ((state == S_MLOAD) || (state == S_MSTEP) || (state == S_MWRITE));
`endif

  alu_ctrl_cnt #(.MULT_CYCLES(MULT_CYCLES)) u_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (state == S_MLOAD),
    .en    (state == S_MSTEP),
    .tc    (tc)
  );

  assign bus.Ready     = ready_o;
  assign bus.Signal    = sig_q;
  assign bus.MultLoad  = mload_o;
  assign bus.MultStep  = mstep_o;
  assign bus.HiLoWrite = hlwr_o;
  assign bus.Done      = done_o;
  assign bus.IllegalOp = ill_o;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq -- self-checking bench for alu_ctrl_seq.
// Table-driven single-cycle vectors, hand-written MULTU / hold-off / reset
// sequences, and random op streams checked against a per-op timing model.
module tb_alu_ctrl_seq;
  localparam int N = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_ctrl_seq_if bus ();

  alu_ctrl_seq #(.MULT_CYCLES(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic dm;
`ifdef ALU_CTRL_DIVU_EN
  assign dm = bus.DivMode;
`else
  assign dm = 1'b0;
`endif

  int checks = 0;
  int fails  = 0;
  logic [5:0] last_sig;

  typedef struct {
    logic [5:0] f;
    logic [5:0] sig;
    logic       ill;
  } vec_t;

  vec_t tbl [8];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] outs();
    return {bus.Ready, bus.Signal, bus.MultLoad, bus.MultStep,
            bus.HiLoWrite, bus.Done, bus.IllegalOp, dm};
  endfunction

  function automatic logic [12:0] pack_exp(input logic rdy, input logic [5:0] sig,
                                           input logic ml, input logic ms,
                                           input logic hw, input logic dn,
                                           input logic il, input logic d);
    return {rdy, sig, ml, ms, hw, dn, il, d};
  endfunction

  task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got {rdy,sig,ml,ms,hw,done,ill,dm}=%b want %b at %0t",
               nm, act, exp, $time);
    end
  endtask

  // 0 = single-cycle legal, 1 = MULTU, 2 = DIVU (enabled), 3 = illegal
  function automatic int kind(input logic [5:0] f);
    case (f)
      6'b100100, 6'b100101, 6'b100000, 6'b100010,
      6'b101010, 6'b000010, 6'b010000, 6'b010010: return 0;
      6'b011001: return 1;
`ifdef ALU_CTRL_DIVU_EN
      6'b011011: return 2;
`endif
      default:   return 3;
    endcase
  endfunction

  // Present f and wait (bounded) for the handshake; returns in cycle T+1.
  task automatic accept(input logic [5:0] f);
    int w;
    bus.FunctIn = f;
    bus.Valid   = 1'b1;
    w = 0;
    while (!bus.Ready && w < 100) begin
      step();
      w++;
    end
    if (!bus.Ready) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: Ready=%b required 1", bus.Ready);
    end
    step();
    bus.Valid = 1'b0;
  endtask

  // Called in cycle T+1; checks every cycle of the op and the Ready cycle after.
  task automatic expect_op(input string nm, input logic [5:0] f);
    int k;
    k = kind(f);
    if (k == 0) last_sig = f;
    if (k == 0 || k == 3) begin
      chk(nm, outs(), pack_exp(1'b0, last_sig, 1'b0, 1'b0, 1'b0, 1'b1, k == 3, 1'b0));
    end else begin
      for (int i = 1; i <= N + 2; i++) begin
        if (i > 1) step();
        chk(nm, outs(), pack_exp(1'b0, last_sig, i == 1, (i >= 2) && (i <= N + 1),
                                 i == N + 2, i == N + 2, 1'b0, k == 2));
      end
    end
    step();
    chk({nm, "_rdy"}, outs(), pack_exp(1'b1, last_sig, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] codes [10];
    logic [5:0] f;

    bus.FunctIn = 6'b0;
    bus.Valid   = 1'b0;

    // Reset state
    step();
    step();
    chk("reset_held", outs(), pack_exp(1'b1, 6'b100000, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    step();
    chk("reset_idle", outs(), pack_exp(1'b1, 6'b100000, 0, 0, 0, 0, 0, 0));
    last_sig = 6'b100000;

    // Single-cycle table, back-to-back at full throughput
    tbl[0] = '{6'b100010, 6'b100010, 1'b0};  // SUB
    tbl[1] = '{6'b100100, 6'b100100, 1'b0};  // AND
    tbl[2] = '{6'b111111, 6'b100100, 1'b1};  // illegal keeps AND
    tbl[3] = '{6'b100101, 6'b100101, 1'b0};  // OR
    tbl[4] = '{6'b000010, 6'b000010, 1'b0};  // SRL
    tbl[5] = '{6'b000000, 6'b000010, 1'b1};  // illegal keeps SRL
    tbl[6] = '{6'b101010, 6'b101010, 1'b0};  // SLT
    tbl[7] = '{6'b100000, 6'b100000, 1'b0};  // ADD
    for (int i = 0; i < 8; i++) begin
      accept(tbl[i].f);
      chk("tbl_exec", outs(), pack_exp(1'b0, tbl[i].sig, 0, 0, 0, 1'b1, tbl[i].ill, 0));
      step();
      chk("tbl_ready", outs(), pack_exp(1'b1, tbl[i].sig, 0, 0, 0, 0, 0, 0));
      last_sig = tbl[i].sig;
    end

    // MULTU with MFHI held pending for the whole sequence
    accept(6'b100010);
    expect_op("sub_pre", 6'b100010);
    accept(6'b011001);
    bus.FunctIn = 6'b010000;
    bus.Valid   = 1'b1;
    expect_op("multu_hold", 6'b011001);
    accept(6'b010000);
    expect_op("mfhi", 6'b010000);

    // DIVU: full sequence with DivMode when enabled, else an illegal pulse
    accept(6'b011011);
    expect_op("divu", 6'b011011);

    // Reset during MSTEP at count 10
    accept(6'b011001);
    for (int i = 0; i < 11; i++) step();
    chk("mstep_cnt10", outs(), pack_exp(1'b0, last_sig, 0, 1'b1, 0, 0, 0, 0));
    reset = 1'b0;
    #1;
    chk("abort_reset", outs(), pack_exp(1'b1, 6'b100000, 0, 0, 0, 0, 0, 0));
    last_sig = 6'b100000;
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < N + 6; i++) begin
      step();
      chk("abort_quiet", outs(), pack_exp(1'b1, 6'b100000, 0, 0, 0, 0, 0, 0));
    end

    // Random op stream with random idle gaps
    codes[0] = 6'b100100; codes[1] = 6'b100101; codes[2] = 6'b100000;
    codes[3] = 6'b100010; codes[4] = 6'b101010; codes[5] = 6'b000010;
    codes[6] = 6'b010000; codes[7] = 6'b010010; codes[8] = 6'b011001;
    codes[9] = 6'b011011;
    for (int n = 0; n < 40; n++) begin
      int gap;
      int r;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        bus.FunctIn = 6'($urandom);
        step();
        chk("rnd_idle", outs(), pack_exp(1'b1, last_sig, 0, 0, 0, 0, 0, 0));
      end
      r = $urandom_range(0, 13);
      if (r < 10) f = codes[r];
      else        f = 6'($urandom);
      accept(f);
      expect_op("rnd_op", f);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
